// File: rtl/fpu_iter_adapter.sv
// fpu_iter_adapter: valid/ready front end for a start/done iterative FP core.
// One operation is in flight at a time. Completed results, or a synthetic
// error entry when the watchdog fires, are queued with their issue tag in a
// small result FIFO.
//
// Handshakes: an input transfer happens on any rising edge where in_valid_i
// and in_ready_o are both high. An output transfer happens on any rising edge
// where out_valid_o and out_ready_i are both high and flush_i is low. Payloads
// must hold steady while valid is high and the transfer has not yet happened.
module fpu_iter_adapter #(
    parameter int WIDTH          = 64,
    parameter int OP_W           = 5,
    parameter int TAG_W          = 8,
    parameter int OUT_DEPTH      = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [3*WIDTH-1:0]   operands_i,
    input  logic [OP_W-1:0]      op_i,
    input  logic [TAG_W-1:0]     tag_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     result_o,
    output logic [4:0]           status_o,
    output logic [TAG_W-1:0]     tag_o,
    output logic                 out_error_o,
    output logic                 busy_o,
    output logic                 core_start_o,
    output logic                 core_abort_o,
    output logic [3*WIDTH-1:0]   core_operands_o,
    output logic [OP_W-1:0]      core_op_o,
    input  logic                 core_done_i,
    input  logic [WIDTH-1:0]     core_result_i,
    input  logic [4:0]           core_status_i,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // FIFO entry layout: {result, status, tag, error}
    localparam int E_W   = WIDTH + 5 + TAG_W + 1;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    // Watchdog counts 0..TIMEOUT_CYCLES-1; the cycle at the last value expires.
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic WD_ON = (TIMEOUT_CYCLES > 0);

    state_t              state;
    logic                start_q;
    logic                abort_q;
    logic [WD_W-1:0]     wd_cnt;
    logic [3*WIDTH-1:0]  operands_q;
    logic [OP_W-1:0]     op_q;
    logic [TAG_W-1:0]    tag_q;

    logic [E_W-1:0]      mem [OUT_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic                accept;
    logic                done_ok;
    logic                wd_expire;
    logic                push;
    logic                pop;
    logic [E_W-1:0]      push_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake, completion and FIFO control decodes
    always_comb begin
        in_ready_o = (state == IDLE) && (count < CNT_W'(OUT_DEPTH)) && !flush_i;
        accept     = in_valid_i && in_ready_o;
        // A done pulse coincident with the launch pulse is stale and ignored.
        done_ok    = core_done_i && !start_q;
        wd_expire  = WD_ON && (wd_cnt == WD_LAST) && !done_ok;
        push       = (state == BUSY) && !flush_i && (done_ok || wd_expire);
        pop        = (count != '0) && out_ready_i && !flush_i;
        push_entry = done_ok ? {core_result_i, core_status_i, tag_q, 1'b0}
                             : {{WIDTH{1'b0}}, 5'b10000, tag_q, 1'b1};
    end

    // Control FSM: launch, wait for done or watchdog, drain after flush
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            wd_cnt     <= '0;
            operands_q <= '0;
            op_q       <= '0;
            tag_q      <= '0;
        end else begin
            start_q <= accept;
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        operands_q <= operands_i;
                        op_q       <= op_i;
                        tag_q      <= tag_i;
                        wd_cnt     <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (done_ok) begin
                        state <= IDLE;
                    end else if (wd_expire) begin
                        abort_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (flush_i) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done_ok) begin
                        state <= IDLE;
                    end else if (wd_expire) begin
                        abort_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result FIFO: flush empties it, otherwise push/pop with wrapping pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Output mapping from registered state and FIFO head
    always_comb begin
        {result_o, status_o, tag_o, out_error_o} = mem[rd_ptr];
        out_valid_o     = (count != '0);
        busy_o          = (state != IDLE) || (count != '0);
        core_start_o    = start_q;
        core_abort_o    = abort_q;
        core_operands_o = operands_q;
        core_op_o       = op_q;
        state_o         = state;
    end

endmodule

// File: doc/fpu_iter_adapter.md
# fpu_iter_adapter

Parametrised handshake adapter between the FPU issue interface and a variable-latency iterative floating-point core driven by start/done pulses. It accepts one operation at a time on a valid/ready interface and launches it on the core. Results are buffered in an OUT_DEPTH-entry result FIFO with the issue tag. The block also handles flush, in-flight result discard, and a watchdog timeout that aborts a hung core.

## Interface
- WIDTH, 64: operand/result width.
- OP_W, 5: opcode width forwarded to core.
- TAG_W, 8: tag width.
- OUT_DEPTH, 2: result FIFO depth, power of two, ≥1.
- TIMEOUT_CYCLES, 256: watchdog limit in cycles; 0 disables the watchdog.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request ready.
- operands_i  in  3*WIDTH  operands a (LSBs), b, c.
- op_i  in  OP_W  opcode.
- tag_i  in  TAG_W  request tag.
- flush_i  in  1  discard in-flight and buffered work.
- out_valid_o  out  1  result valid (FIFO non-empty).
- out_ready_i  in  1  result consumed.
- result_o  out  WIDTH  FIFO head result.
- status_o  out  5  FIFO head flags {NV,DZ,OF,UF,NX}.
- tag_o  out  TAG_W  FIFO head tag.
- out_error_o  out  1  FIFO head produced by timeout.
- busy_o  out  1  state≠IDLE or FIFO non-empty.
- core_start_o  out  1  one-cycle launch pulse.
- core_abort_o  out  1  one-cycle abort pulse.
- core_operands_o  out  3*WIDTH  registered operands.
- core_op_o  out  OP_W  registered opcode.
- core_done_i  in  1  one-cycle completion pulse.
- core_result_i  in  WIDTH  valid with core_done_i.
- core_status_i  in  5  valid with core_done_i.

## Operation
- States: IDLE, BUSY, DRAIN.
- in_ready_o = (state==IDLE) && (fifo_count<OUT_DEPTH) && !flush_i. This is combinational.
- Accept when in_valid_i && in_ready_o:
  - Register operands, op and tag.
  - Assert core_start_o the next cycle.
  - Go to BUSY and clear the watchdog counter.
- In BUSY, core_done_i is honoured from the cycle after core_start_o. A done coincident with core_start_o is ignored.
- BUSY with core_done_i: push {core_result_i, core_status_i, tag, error=0} into the FIFO, then go to IDLE.
- BUSY with no done:
  - The watchdog increments each cycle.
  - On reaching TIMEOUT_CYCLES (nonzero): pulse core_abort_o, push {result=0, status=5'b10000, tag, error=1}, go to IDLE.
- A push never overflows: acceptance requires a free slot and only one operation is in flight.
- Flush:
  - The FIFO is emptied (pointers and count cleared).
  - BUSY goes to DRAIN.
  - In DRAIN, the next core_done_i is discarded and the state returns to IDLE. The watchdog also runs in DRAIN; on expiry it pulses core_abort_o, goes to IDLE and pushes nothing.
  - Flush in IDLE only clears the FIFO.
- Flush in the same cycle as core_done_i while BUSY: the result is discarded and the state goes to IDLE.
- Pop when out_valid_o && out_ready_i. Read and write pointers wrap modulo OUT_DEPTH.
- Push and pop in the same cycle: count is unchanged; both pointers advance.
- Pop on the cycle flush_i is asserted: ignored, because flush wins.

## Timing
- Request accepted at cycle T:
  - core_start_o is high in T+1 only.
  - A core_done_i at T+1+L (L≥1) gives out_valid_o at T+2+L.
- Minimum issue-to-result latency is 3 cycles.
- A new request can be accepted in the cycle after the push, provided the FIFO is not full.
- FIFO outputs are registered; the head is stable while out_valid_o && !out_ready_i.
- Reset (any state, asynchronous):
  - State IDLE, FIFO empty, watchdog 0.
  - Outputs: out_valid_o=0, core_start_o=0, core_abort_o=0, busy_o=0.
  - core_operands_o, core_op_o and the FIFO head outputs are 0.
  - in_ready_o=1 once rst_i deasserts (with flush_i low).

## Test plan
- Single op: accept opA=0x3FF0000000000000 with tag 0x12; core_done_i 4 cycles after start with result 0x4000000000000000 and status 0. Expect out_valid_o 1 cycle later with the same result, tag 0x12 and error 0.
- Backpressure with OUT_DEPTH=2 and out_ready_i=0: after two completions, in_ready_o=0. One pop lets a third op issue. Results emerge in order (tags 1,2,3).
- Flush while BUSY: flush 2 cycles after start, then core_done_i 3 cycles later. Expect no out_valid_o, state returns to IDLE, and the next op is accepted normally.
- Timeout with TIMEOUT_CYCLES=8 and no core_done_i: core_abort_o pulses once. The head then shows error=1, status=5'b10000, and the original tag.
- Simultaneous push and pop with the FIFO holding 1 entry: count stays 1 and the pointer wrap is correct across 10 back-to-back ops.
- Async reset asserted mid-BUSY: all outputs take reset values immediately, and a late core_done_i is ignored after release.
